// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scan controller.
// Width functions are constant-evaluable so they can size ports and counters.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  localparam int MAX_LINES = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int code_width(input int n_rows, input int n_cols);
    return $clog2(n_rows) + $clog2(n_cols);
  endfunction

  function automatic int cnt_width(input int settle, input int debounce, input int repeat_cyc);
    return $clog2(max3(settle, debounce, repeat_cyc) + 1);
  endfunction

  function automatic logic is_onehot(input logic [MAX_LINES-1:0] v);
    return (v != '0) && ((v & (v - MAX_LINES'(1))) == '0);
  endfunction

  // Only meaningful for one-hot input; the highest set bit wins otherwise.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_LINES-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, any width.
// Reset clears both stages so the FSM sees an idle bus out of reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: row drive, column debounce, key encode, multi-key
// rejection and optional auto-repeat.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   SCAN     | drive one row, settle, then sample columns; advance if idle
//   DEBOUNCE | row held; waiting for DEBOUNCE_CYC stable samples of pat
//   PRESSED  | key accepted; optional repeat strobes until columns clear
//   RELEASE  | waiting for DEBOUNCE_CYC consecutive empty samples
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int SETTLE_CYC   = 3,
  parameter int DEBOUNCE_CYC = 8,
  parameter int REPEAT_CYC   = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_COLS-1:0]                      columns,
  output logic [N_ROWS-1:0]                      rows,
  output logic                                   key_valid,
  output logic [code_width(N_ROWS, N_COLS)-1:0]  key_code,
  output logic [N_ROWS+N_COLS-1:0]               key_raw,
  output logic                                   key_held,
  output logic                                   multi_key
);

  localparam int RW    = $clog2(N_ROWS);
  localparam int CW    = $clog2(N_COLS);
  localparam int CNT_W = cnt_width(SETTLE_CYC, DEBOUNCE_CYC, REPEAT_CYC);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DB_DONE     = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
  localparam logic [RW-1:0]    ROW_LAST    = RW'(N_ROWS - 1);

  scan_state_e         state;
  logic [N_COLS-1:0]   col_s;
  logic [N_COLS-1:0]   pat;
  logic [RW-1:0]       row_idx;
  logic [RW-1:0]       row_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    db_cnt;
  logic [CNT_W-1:0]    rep_cnt;
  logic                rep_en;
  logic                pat_single;
  logic [CW-1:0]       pat_idx;

  sync_2ff #(
    .WIDTH (N_COLS)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (columns),
    .q     (col_s)
  );

  assign row_next   = (row_idx == ROW_LAST) ? '0 : row_idx + RW'(1);
  assign pat_single = is_onehot(MAX_LINES'(pat));
  assign pat_idx    = CW'(onehot_to_idx(MAX_LINES'(pat)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      row_idx   <= '0;
      rows      <= N_ROWS'(1);
      cnt       <= '0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      rep_en    <= 1'b0;
      pat       <= '0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
      key_held  <= 1'b0;
      key_code  <= '0;
      key_raw   <= '0;
    end else begin
      key_valid <= 1'b0;
      multi_key <= 1'b0;

      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (col_s == '0) begin
              row_idx <= row_next;
              rows    <= N_ROWS'(1) << row_next;
            end else begin
              pat    <= col_s;
              db_cnt <= CNT_W'(1);
              state  <= DEBOUNCE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Mismatch checks come first so a bounce on the final sample restarts.
        DEBOUNCE: begin
          if (col_s == '0) begin
            db_cnt <= '0;
            cnt    <= '0;
            state  <= SCAN;
          end else if (col_s != pat) begin
            pat    <= col_s;
            db_cnt <= CNT_W'(1);
          end else if (db_cnt == DB_DONE) begin
            db_cnt   <= '0;
            rep_cnt  <= '0;
            key_held <= 1'b1;
            state    <= PRESSED;
            rep_en   <= pat_single && (REPEAT_CYC > 0);
            if (pat_single) begin
              key_valid <= 1'b1;
              key_code  <= {row_idx, pat_idx};
              key_raw   <= {rows, pat};
            end else begin
              multi_key <= 1'b1;
            end
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (col_s == '0) begin
            rep_cnt <= '0;
            db_cnt  <= CNT_W'(1);
            state   <= RELEASE;
          end else if (rep_en) begin
            if (rep_cnt == REP_LAST) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
            end else begin
              rep_cnt <= rep_cnt + CNT_W'(1);
            end
          end
        end

        RELEASE: begin
          if (col_s != '0) begin
            db_cnt  <= '0;
            rep_cnt <= '0;
            state   <= PRESSED;
          end else if (db_cnt == DB_DONE) begin
            db_cnt   <= '0;
            cnt      <= '0;
            key_held <= 1'b0;
            row_idx  <= row_next;
            rows     <= N_ROWS'(1) << row_next;
            state    <= SCAN;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a default instance and an auto-repeat instance,
// each driven by a resistive keypad model and checked against a strobe scoreboard.
module tb_keypad_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] key_a, key_b;
  logic [3:0]  cols_a, cols_b, rows_a, rows_b, code_a, code_b;
  logic [7:0]  raw_a, raw_b;
  logic        kv_a, kv_b, held_a, held_b, multi_a, multi_b;

  keypad_scan_ctrl #(
    .N_ROWS(4), .N_COLS(4), .SETTLE_CYC(3), .DEBOUNCE_CYC(8), .REPEAT_CYC(0)
  ) dut (
    .clk(clk), .reset(rst_n), .columns(cols_a), .rows(rows_a), .key_valid(kv_a),
    .key_code(code_a), .key_raw(raw_a), .key_held(held_a), .multi_key(multi_a)
  );

  keypad_scan_ctrl #(
    .N_ROWS(4), .N_COLS(4), .SETTLE_CYC(3), .DEBOUNCE_CYC(8), .REPEAT_CYC(20)
  ) dut_rep (
    .clk(clk), .reset(rst_n), .columns(cols_b), .rows(rows_b), .key_valid(kv_b),
    .key_code(code_b), .key_raw(raw_b), .key_held(held_b), .multi_key(multi_b)
  );

  // key bit r*4+c closed connects row r to column c
  always_comb begin
    cols_a = '0;
    cols_b = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cols_a[c] = cols_a[c] | (rows_a[r] & key_a[r*4+c]);
        cols_b[c] = cols_b[c] | (rows_b[r] & key_b[r*4+c]);
      end
    end
  end

  typedef struct {
    bit         multi;
    logic [3:0] code;
    logic [7:0] raw;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   ea, eb;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     rep_times[$];
  logic   prev_kv_a = 1'b0;
  logic   prev_kv_b = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (kv_a || multi_a) begin
        check_eq("a_strobe_expected", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          ea = q_a.pop_front();
          check_eq("a_kind", multi_a, ea.multi);
          check_eq("a_kv_vs_kind", kv_a, !ea.multi);
          if (kv_a) begin
            check_eq("a_key_code", code_a, ea.code);
            check_eq("a_key_raw", raw_a, ea.raw);
          end
        end
      end
      if (kv_a) check_eq("a_kv_width", prev_kv_a, 0);
      prev_kv_a = kv_a;

      if (kv_b || multi_b) begin
        check_eq("b_strobe_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          eb = q_b.pop_front();
          check_eq("b_kind", multi_b, eb.multi);
          if (kv_b) begin
            check_eq("b_key_code", code_b, eb.code);
            check_eq("b_key_raw", raw_b, eb.raw);
            rep_times.push_back(cyc);
          end
        end
      end
      if (kv_b) check_eq("b_kv_width", prev_kv_b, 0);
      prev_kv_b = kv_b;
    end else begin
      prev_kv_a = 1'b0;
      prev_kv_b = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic found;
    exp_t e;

    rst_n = 1'b0;
    key_a = '0;
    key_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rows", rows_a, 4'b0001);
    check_eq("rst_kv", kv_a, 0);
    check_eq("rst_code", code_a, 0);
    check_eq("rst_raw", raw_a, 0);
    check_eq("rst_held", held_a, 0);
    check_eq("rst_multi", multi_a, 0);

    // idle scan: 3 cycles per row, 1,2,4,8,1...
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      check_eq("idle_rows_a", rows_a, 4'b0001 << ((k / 3) % 4));
      check_eq("idle_rows_b", rows_b, 4'b0001 << ((k / 3) % 4));
    end

    // clean press row 2 / col 1
    @(negedge clk);
    key_a = 16'h1 << (2*4 + 1);
    e = '{multi: 1'b0, code: 4'b1001, raw: 8'b0100_0010};
    q_a.push_back(e);
    repeat (30) @(negedge clk);
    check_eq("press_held", held_a, 1);
    key_a = '0;
    // column falls half a cycle before edge 1; rows move on edge 11
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (rows_a !== 4'b0100) break;
    end
    check_eq("release_latency", n, 11);
    check_eq("release_next_row", rows_a, 4'b1000);
    check_eq("release_held", held_a, 0);
    repeat (5) @(negedge clk);
    check_eq("press_q_empty", q_a.size(), 0);

    // bouncing row 0 / col 3, then stable
    e = '{multi: 1'b0, code: 4'b0011, raw: 8'b0001_1000};
    q_a.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_a = (((i / 3) % 2) == 0) ? 16'h0008 : 16'h0000;
    end
    check_eq("bounce_no_strobe", q_a.size(), 1);
    @(negedge clk);
    key_a = 16'h0008;
    repeat (40) @(negedge clk);
    key_a = '0;
    repeat (20) @(negedge clk);
    check_eq("bounce_q_empty", q_a.size(), 0);

    // two keys on row 1
    e = '{multi: 1'b1, code: 4'b0000, raw: 8'b0000_0000};
    q_a.push_back(e);
    @(negedge clk);
    key_a = (16'h1 << 4) | (16'h1 << 6);
    repeat (30) @(negedge clk);
    check_eq("multi_held", held_a, 1);
    key_a = '0;
    repeat (20) @(negedge clk);
    check_eq("multi_held_after", held_a, 0);
    check_eq("multi_q_empty", q_a.size(), 0);

    // auto-repeat: press row 3 / col 2 on the first cycle row 3 is driven
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rows_b == 4'b0100) found = 1'b1;
    end
    check_eq("rep_sync_row2", found, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rows_b == 4'b1000) found = 1'b1;
    end
    check_eq("rep_sync_row3", found, 1);
    key_b = 16'h1 << (3*4 + 2);
    rep_times.delete();
    for (int i = 0; i < 5; i++) begin
      e = '{multi: 1'b0, code: 4'b1110, raw: 8'b1000_0100};
      q_b.push_back(e);
    end
    repeat (100) @(negedge clk);
    key_b = '0;
    repeat (20) @(negedge clk);
    check_eq("rep_q_empty", q_b.size(), 0);
    check_eq("rep_count", rep_times.size(), 5);
    for (int i = 1; i < rep_times.size(); i++) begin
      check_eq("rep_period", rep_times[i] - rep_times[i-1], 20);
    end

    // reset while key_valid is high
    @(negedge clk);
    key_a = 16'h1 << (2*4 + 1);
    e = '{multi: 1'b0, code: 4'b1001, raw: 8'b0100_0010};
    q_a.push_back(e);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (kv_a) found = 1'b1;
    end
    check_eq("rst_kv_seen", found, 1);
    #2;
    rst_n = 1'b0;
    key_a = '0;
    #1;
    check_eq("rst_kv_drop", kv_a, 0);
    check_eq("rst_mid_rows", rows_a, 4'b0001);
    check_eq("rst_mid_code", code_a, 0);
    check_eq("rst_mid_held", held_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_rows", rows_a, 4'b0001);
    @(posedge clk);
    #1;
    check_eq("rst_release_rows_e1", rows_a, 4'b0001);
    repeat (3) @(negedge clk);
    check_eq("rst_q_empty", q_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
